// File: rtl/switch_allocator_sep_if.sv
// switch_allocator_sep_if
//   Bundle between the input block and the separable switch allocator.
//   The input block (master) presents per-input/per-VC requests together with
//   the routed output port and the downstream VC, and returns credits from the
//   next router. The allocator (slave) answers with one VC grant per input and
//   the crossbar select per output.
//   Signals:
//     switch_request [PORT_NUM][VC_NUM]          input VC wants to send a flit
//     out_port       [PORT_NUM][VC_NUM] port     output port of each input VC
//     downstream_vc  [PORT_NUM][VC_NUM] vc       VC allocated in the next router
//     credit_in      [PORT_NUM][VC_NUM]          one credit back for (output, VC)
//     vc_sel         [PORT_NUM] vc               granted VC of each input
//     valid_sel      [PORT_NUM]                  input granted this cycle
//     xbar_select    [PORT_NUM] port             input feeding each output
//     valid_flit_out [PORT_NUM]                  output carries a flit next cycle
interface switch_allocator_sep_if #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 2,
  parameter int VC_SIZE  = 1,
  parameter int PORT_W   = $clog2(PORT_NUM)
);
  logic [PORT_NUM-1:0][VC_NUM-1:0]              switch_request;
  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_W-1:0]  out_port;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc;
  logic [PORT_NUM-1:0][VC_NUM-1:0]              credit_in;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]             vc_sel;
  logic [PORT_NUM-1:0]                          valid_sel;
  logic [PORT_NUM-1:0][PORT_W-1:0]              xbar_select;
  logic [PORT_NUM-1:0]                          valid_flit_out;

  modport master (
    output switch_request, out_port, downstream_vc, credit_in,
    input  vc_sel, valid_sel, xbar_select, valid_flit_out
  );

  modport slave (
    input  switch_request, out_port, downstream_vc, credit_in,
    output vc_sel, valid_sel, xbar_select, valid_flit_out
  );
endinterface

// File: rtl/switch_allocator_sep.sv
// switch_allocator_sep
//   Separable input-first switch allocator with downstream credit tracking.
//   Stage 1 picks one eligible VC per input (round-robin from in_ptr), stage 2
//   picks one stage-1 winner per output (round-robin from out_ptr). Grants are
//   combinational in the request cycle; pointers and credits update on clk.
//   A VC is eligible only while its (output, downstream VC) has credit.
//   Ports:
//     clk  in  clock, all state on the rising edge
//     rst  in  asynchronous reset, active-low; forces every output to 0
//     sa   slave modport of switch_allocator_sep_if (requests in, grants out)
module switch_allocator_sep #(
  parameter int PORT_NUM    = 5,
  parameter int VC_NUM      = 2,
  parameter int VC_SIZE     = 1,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  switch_allocator_sep_if.slave sa
);

  localparam int PORT_W = $clog2(PORT_NUM);
  localparam int CRED_W = $clog2(BUFFER_SIZE + 1);

  typedef logic [PORT_W-1:0] port_t;
  localparam port_t LOCAL = '0;

  function automatic logic [VC_SIZE-1:0] vc_wrap(input int x);
    return VC_SIZE'(x % VC_NUM);
  endfunction

  function automatic port_t port_wrap(input int x);
    return PORT_W'(x % PORT_NUM);
  endfunction

  logic [VC_SIZE-1:0]             in_ptr [PORT_NUM];
  port_t                          out_ptr [PORT_NUM];
  logic [CRED_W-1:0]              credit [PORT_NUM][VC_NUM];

  logic [PORT_NUM-1:0][VC_NUM-1:0] elig;
  logic [PORT_NUM-1:0]             w1_vld;
  logic [VC_SIZE-1:0]              w1 [PORT_NUM];
  logic [PORT_NUM-1:0]             out_gnt;
  port_t                           out_win [PORT_NUM];
  logic [PORT_NUM-1:0]             in_gnt;
  logic [PORT_NUM-1:0][VC_NUM-1:0] dec;

  // Eligibility: request plus a free slot in the chosen downstream VC
  always_comb begin
    elig = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        elig[i][v] = sa.switch_request[i][v] &&
                     (credit[sa.out_port[i][v]][sa.downstream_vc[i][v]] != '0);
      end
    end
  end

  // Stage 1: per-input round-robin over VCs
  always_comb begin
    logic [VC_SIZE-1:0] vc;
    vc     = '0;
    w1_vld = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      w1[i] = '0;
      for (int k = 0; k < VC_NUM; k++) begin
        vc = vc_wrap(int'(in_ptr[i]) + k);
        if (!w1_vld[i] && elig[i][vc]) begin
          w1_vld[i] = 1'b1;
          w1[i]     = vc;
        end
      end
    end
  end

  // Stage 2: per-output round-robin over inputs holding a stage-1 winner
  always_comb begin
    port_t src;
    src     = LOCAL;
    out_gnt = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      out_win[o] = LOCAL;
      for (int k = 0; k < PORT_NUM; k++) begin
        src = port_wrap(int'(out_ptr[o]) + k);
        if (!out_gnt[o] && w1_vld[src] && (sa.out_port[src][w1[src]] == port_t'(o))) begin
          out_gnt[o] = 1'b1;
          out_win[o] = src;
        end
      end
    end
  end

  // Map output grants back to inputs and to the credit counter they consume
  always_comb begin
    in_gnt = '0;
    dec    = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      if (out_gnt[o]) begin
        in_gnt[out_win[o]] = 1'b1;
        dec[o][sa.downstream_vc[out_win[o]][w1[out_win[o]]]] = 1'b1;
      end
    end
  end

  // Outputs are forced low for as long as reset is held, without waiting for a clock
  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      sa.valid_sel[i] = rst && in_gnt[i];
      sa.vc_sel[i]    = (rst && in_gnt[i]) ? w1[i] : '0;
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      sa.valid_flit_out[o] = rst && out_gnt[o];
      sa.xbar_select[o]    = (rst && out_gnt[o]) ? out_win[o] : LOCAL;
    end
  end

  // State update: pointers advance past the winner only on a full grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PORT_NUM; i++) begin
        in_ptr[i]  <= '0;
        out_ptr[i] <= LOCAL;
        for (int v = 0; v < VC_NUM; v++) begin
          credit[i][v] <= CRED_W'(BUFFER_SIZE);
        end
      end
    end else begin
      for (int i = 0; i < PORT_NUM; i++) begin
        if (in_gnt[i]) begin
          in_ptr[i] <= vc_wrap(int'(w1[i]) + 1);
        end
      end
      for (int o = 0; o < PORT_NUM; o++) begin
        if (out_gnt[o]) begin
          out_ptr[o] <= port_wrap(int'(out_win[o]) + 1);
        end
        for (int v = 0; v < VC_NUM; v++) begin
          if (dec[o][v] && !sa.credit_in[o][v]) begin
            credit[o][v] <= credit[o][v] - CRED_W'(1);
          end else if (sa.credit_in[o][v] && !dec[o][v] &&
                       (credit[o][v] != CRED_W'(BUFFER_SIZE))) begin
            // A return at full is a protocol error; the counter saturates
            credit[o][v] <= credit[o][v] + CRED_W'(1);
          end
        end
      end
    end
  end

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out_chk
    logic [PORT_NUM-1:0] tgt;
    always_comb begin
      tgt = '0;
      for (int i = 0; i < PORT_NUM; i++) begin
        tgt[i] = in_gnt[i] && (sa.out_port[i][w1[i]] == port_t'(o));
      end
    end

    a_onehot_out: assert property (@(posedge clk) disable iff (!rst) $onehot0(tgt));

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc_chk
      a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(dec[o][v] && (credit[o][v] == '0)));
      a_no_inc_full: assert property (@(posedge clk) disable iff (!rst)
        !(sa.credit_in[o][v] && !dec[o][v] && (credit[o][v] == CRED_W'(BUFFER_SIZE))));
    end
  end

endmodule
